// File: rtl/wbk.sv
// Write-back stage: integer register file (x0 hardwired to zero, 1-cycle commit) plus 64-bit cycle/instret counters.
// Optional WBK_BYPASS_EN: same-cycle write-through from the commit port to both read ports.
module wbk #(
  parameter int XLEN    = 32,
  parameter int NB_REGS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               res_w_v_q_i,
  input  logic [NB_REGS-1:0] instr_write_adr_q_i,
  input  logic [XLEN-1:0]    instr_wbk_data_q_i,
  input  logic               instr_retire_v_q_i,
  input  logic [NB_REGS-1:0] rs1_adr_i,
  input  logic [NB_REGS-1:0] rs2_adr_i,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  input  logic               cnt_wr_v_i,
  input  logic [1:0]         cnt_sel_i,
  input  logic [31:0]        cnt_wr_data_i,
  output logic [31:0]        cnt_rd_data_o,
  output logic [63:0]        cycle_q_o,
  output logic [63:0]        instret_q_o
);

  localparam int NREGS = 2 ** NB_REGS;

  localparam logic [1:0] SEL_CYCLE_LO   = 2'b00;
  localparam logic [1:0] SEL_CYCLE_HI   = 2'b01;
  localparam logic [1:0] SEL_INSTRET_LO = 2'b10;
  localparam logic [1:0] SEL_INSTRET_HI = 2'b11;

  logic [XLEN-1:0] regs [NREGS];
  logic            commit;

  logic [63:0] cycle_q, cycle_nxt;
  logic [63:0] instret_q, instret_nxt;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign commit = res_w_v_q_i && (instr_write_adr_q_i != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[instr_write_adr_q_i] <= instr_wbk_data_q_i;
    end
  end

`ifdef WBK_BYPASS_EN
  always_comb begin
    rs1_data_o = regs[rs1_adr_i];
    if (rs1_adr_i == '0) begin
      rs1_data_o = '0;
    end else if (commit && (rs1_adr_i == instr_write_adr_q_i)) begin
      rs1_data_o = instr_wbk_data_q_i;
    end
  end

  always_comb begin
    rs2_data_o = regs[rs2_adr_i];
    if (rs2_adr_i == '0) begin
      rs2_data_o = '0;
    end else if (commit && (rs2_adr_i == instr_write_adr_q_i)) begin
      rs2_data_o = instr_wbk_data_q_i;
    end
  end
`else
  // Without bypass, a same-cycle read of the commit target sees the old value.
  assign rs1_data_o = (rs1_adr_i == '0) ? '0 : regs[rs1_adr_i];
  assign rs2_data_o = (rs2_adr_i == '0) ? '0 : regs[rs2_adr_i];
`endif

  // A write to either half of a counter freezes the other half and drops that cycle's increment.
  always_comb begin
    cycle_nxt = cycle_q + 64'd1;
    if (cnt_wr_v_i) begin
      case (cnt_sel_i)
        SEL_CYCLE_LO: cycle_nxt = {cycle_q[63:32], cnt_wr_data_i};
        SEL_CYCLE_HI: cycle_nxt = {cnt_wr_data_i, cycle_q[31:0]};
        default:      cycle_nxt = cycle_q + 64'd1;
      endcase
    end
  end

  always_comb begin
    instret_nxt = instr_retire_v_q_i ? (instret_q + 64'd1) : instret_q;
    if (cnt_wr_v_i) begin
      case (cnt_sel_i)
        SEL_INSTRET_LO: instret_nxt = {instret_q[63:32], cnt_wr_data_i};
        SEL_INSTRET_HI: instret_nxt = {cnt_wr_data_i, instret_q[31:0]};
        default:        instret_nxt = instr_retire_v_q_i ? (instret_q + 64'd1) : instret_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_nxt;
      instret_q <= instret_nxt;
    end
  end

  always_comb begin
    case (cnt_sel_i)
      SEL_CYCLE_LO:   cnt_rd_data_o = cycle_q[31:0];
      SEL_CYCLE_HI:   cnt_rd_data_o = cycle_q[63:32];
      SEL_INSTRET_LO: cnt_rd_data_o = instret_q[31:0];
      default:        cnt_rd_data_o = instret_q[63:32];
    endcase
  end

  assign cycle_q_o   = cycle_q;
  assign instret_q_o = instret_q;

endmodule

// File: tb/tb_wbk.sv
// Directed bench for wbk: expected values are queued as each step is driven and popped when the output is sampled.
module tb_wbk;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_w_v_q_i;
  logic [4:0]  instr_write_adr_q_i;
  logic [31:0] instr_wbk_data_q_i;
  logic        instr_retire_v_q_i;
  logic [4:0]  rs1_adr_i;
  logic [4:0]  rs2_adr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        cnt_wr_v_i;
  logic [1:0]  cnt_sel_i;
  logic [31:0] cnt_wr_data_i;
  logic [31:0] cnt_rd_data_o;
  logic [63:0] cycle_q_o;
  logic [63:0] instret_q_o;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  wbk dut (
    .clk                 (clk),
    .reset               (reset),
    .res_w_v_q_i         (res_w_v_q_i),
    .instr_write_adr_q_i (instr_write_adr_q_i),
    .instr_wbk_data_q_i  (instr_wbk_data_q_i),
    .instr_retire_v_q_i  (instr_retire_v_q_i),
    .rs1_adr_i           (rs1_adr_i),
    .rs2_adr_i           (rs2_adr_i),
    .rs1_data_o          (rs1_data_o),
    .rs2_data_o          (rs2_data_o),
    .cnt_wr_v_i          (cnt_wr_v_i),
    .cnt_sel_i           (cnt_sel_i),
    .cnt_wr_data_i       (cnt_wr_data_i),
    .cnt_rd_data_o       (cnt_rd_data_o),
    .cycle_q_o           (cycle_q_o),
    .instret_q_o         (instret_q_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge and outputs are sampled 2 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    reset               = 1'b1;
    res_w_v_q_i         = 1'b0;
    instr_write_adr_q_i = '0;
    instr_wbk_data_q_i  = '0;
    instr_retire_v_q_i  = 1'b0;
    rs1_adr_i           = '0;
    rs2_adr_i           = '0;
    cnt_wr_v_i          = 1'b0;
    cnt_sel_i           = 2'b00;
    cnt_wr_data_i       = '0;

    // Reset for one edge, then counters start from zero.
    tick();
    reset = 1'b0;
    #1;
    push_exp("rst_cycle", 64'd0);            check(cycle_q_o);
    push_exp("rst_instret", 64'd0);          check(instret_q_o);
    tick();
    #1;
    push_exp("cycle_after_rst", 64'd1);      check(cycle_q_o);

    for (int i = 0; i < 32; i++) begin
      rs1_adr_i = 5'(i);
      rs2_adr_i = 5'(31 - i);
      #1;
      push_exp($sformatf("rst_rs1_x%0d", i), 64'd0);      check(64'(rs1_data_o));
      push_exp($sformatf("rst_rs2_x%0d", 31 - i), 64'd0); check(64'(rs2_data_o));
      tick();
    end

    // Commit x5, read it back next cycle; a write to x0 is dropped.
    res_w_v_q_i = 1'b1; instr_write_adr_q_i = 5'd5; instr_wbk_data_q_i = 32'hDEAD_BEEF;
    tick();
    res_w_v_q_i = 1'b0; rs1_adr_i = 5'd5;
    #1;
    push_exp("x5_read", 64'hDEAD_BEEF);      check(64'(rs1_data_o));
    res_w_v_q_i = 1'b1; instr_write_adr_q_i = 5'd0; instr_wbk_data_q_i = 32'h0000_1234;
    tick();
    res_w_v_q_i = 1'b0; rs2_adr_i = 5'd0;
    #1;
    push_exp("x0_read", 64'd0);              check(64'(rs2_data_o));
    push_exp("x5_keep", 64'hDEAD_BEEF);      check(64'(rs1_data_o));

    // Same-cycle read of the commit target.
    rs1_adr_i = 5'd7; rs2_adr_i = 5'd5;
    res_w_v_q_i = 1'b1; instr_write_adr_q_i = 5'd7; instr_wbk_data_q_i = 32'hA5A5_A5A5;
    #1;
`ifdef WBK_BYPASS_EN
    push_exp("x7_same_cycle", 64'hA5A5_A5A5);
`else
    push_exp("x7_same_cycle", 64'd0);
`endif
    check(64'(rs1_data_o));
    push_exp("x5_other_port", 64'hDEAD_BEEF); check(64'(rs2_data_o));
    tick();
    res_w_v_q_i = 1'b0;
    #1;
    push_exp("x7_next_cycle", 64'hA5A5_A5A5); check(64'(rs1_data_o));

    // x0 read while a (dropped) x0 write is in flight never forwards.
    rs1_adr_i = 5'd0;
    res_w_v_q_i = 1'b1; instr_write_adr_q_i = 5'd0; instr_wbk_data_q_i = 32'hFFFF_FFFF;
    #1;
    push_exp("x0_no_bypass", 64'd0);         check(64'(rs1_data_o));
    tick();
    res_w_v_q_i = 1'b0;

    // Cycle low-half write, then carry into the high half.
    cnt_wr_v_i = 1'b1; cnt_sel_i = 2'b00; cnt_wr_data_i = 32'hFFFF_FFFF;
    tick();
    cnt_wr_v_i = 1'b0;
    #1;
    push_exp("cycle_lo_wr", 64'h0000_0000_FFFF_FFFF); check(cycle_q_o);
    tick();
    #1;
    push_exp("cycle_carry", 64'h0000_0001_0000_0000); check(cycle_q_o);

    cnt_wr_v_i = 1'b1; cnt_sel_i = 2'b00; cnt_wr_data_i = 32'hFFFF_FFFF;
    tick();
    cnt_sel_i = 2'b01;
    #1;
    push_exp("cnt_rd_old_hi", 64'd1);        check(64'(cnt_rd_data_o));
    tick();
    cnt_wr_v_i = 1'b0;
    #1;
    push_exp("cycle_hi_wr", 64'hFFFF_FFFF_FFFF_FFFF); check(cycle_q_o);
    push_exp("instret_untouched", 64'd0);   check(instret_q_o);
    tick();
    #1;
    push_exp("cycle_wrap", 64'd0);           check(cycle_q_o);
    push_exp("cnt_rd_cycle_hi", 64'd0);      check(64'(cnt_rd_data_o));

    // Counter write beats a simultaneous retire; next retire increments.
    instr_retire_v_q_i = 1'b1;
    cnt_wr_v_i = 1'b1; cnt_sel_i = 2'b10; cnt_wr_data_i = 32'h0000_0010;
    #1;
    push_exp("cnt_rd_old_instret", 64'd0);   check(64'(cnt_rd_data_o));
    tick();
    cnt_wr_v_i = 1'b0;
    #1;
    push_exp("instret_wr_wins", 64'h10);     check(instret_q_o);
    push_exp("cnt_rd_instret_lo", 64'h10);   check(64'(cnt_rd_data_o));
    tick();
    instr_retire_v_q_i = 1'b0;
    #1;
    push_exp("instret_inc", 64'h11);         check(instret_q_o);

    // High-half write holds the low half even with a retire pending.
    instr_retire_v_q_i = 1'b1;
    cnt_wr_v_i = 1'b1; cnt_sel_i = 2'b11; cnt_wr_data_i = 32'h0000_0002;
    tick();
    instr_retire_v_q_i = 1'b0; cnt_wr_v_i = 1'b0;
    #1;
    push_exp("instret_hi_wr", 64'h0000_0002_0000_0011); check(instret_q_o);

    // instret 64-bit wrap.
    cnt_wr_v_i = 1'b1; cnt_sel_i = 2'b10; cnt_wr_data_i = 32'hFFFF_FFFF;
    tick();
    cnt_sel_i = 2'b11;
    tick();
    cnt_wr_v_i = 1'b0; instr_retire_v_q_i = 1'b1;
    #1;
    push_exp("instret_max", 64'hFFFF_FFFF_FFFF_FFFF); check(instret_q_o);
    tick();
    instr_retire_v_q_i = 1'b0;
    #1;
    push_exp("instret_wrap", 64'd0);         check(instret_q_o);

    // Reset wins over a commit, a retire and a counter write in the same cycle.
    res_w_v_q_i = 1'b1; instr_write_adr_q_i = 5'd3; instr_wbk_data_q_i = 32'h0000_0055;
    instr_retire_v_q_i = 1'b1;
    cnt_wr_v_i = 1'b1; cnt_sel_i = 2'b00; cnt_wr_data_i = 32'h0000_0077;
    reset = 1'b1;
    tick();
    reset = 1'b0; res_w_v_q_i = 1'b0; instr_retire_v_q_i = 1'b0; cnt_wr_v_i = 1'b0;
    rs1_adr_i = 5'd3; rs2_adr_i = 5'd5;
    #1;
    push_exp("x3_after_rst", 64'd0);         check(64'(rs1_data_o));
    push_exp("x5_after_rst", 64'd0);         check(64'(rs2_data_o));
    push_exp("instret_after_rst", 64'd0);    check(instret_q_o);
    push_exp("cycle_after_rst_wr", 64'd0);   check(cycle_q_o);
    tick();
    #1;
    push_exp("cycle_restart", 64'd1);        check(cycle_q_o);

    n_tests++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
